// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the Cardinal NIC: register-window addresses,
// packet word type, VC bit position and the channel-buffer state encoding.
package cardinal_nic_pkg;

  typedef logic [0:63] packet_t;

  localparam logic [0:1] NIC_IN_BUF   = 2'b00;
  localparam logic [0:1] NIC_IN_STAT  = 2'b01;
  localparam logic [0:1] NIC_OUT_BUF  = 2'b10;
  localparam logic [0:1] NIC_OUT_STAT = 2'b11;

  // Packet bit 0 (MSB, big-endian numbering) selects the virtual channel.
  localparam int unsigned VC_BIT = 0;

  // A channel buffer's state is its full flag.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/cardinal_nic_if.sv
// Bundle of processor-side register-window signals and ring-router local-port
// signals for the Cardinal NIC.
//   slave  : NIC view (drives d_out, net_ri, net_so, net_do)
//   master : processor + router view (drives everything else)
interface cardinal_nic_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic [0:ADDR_WIDTH-1] addr;
  logic [0:DATA_WIDTH-1] d_in;
  logic [0:DATA_WIDTH-1] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic_channel_buf.sv
// nic_channel_buf: single-entry packet buffer with a full flag.
//   Clock, Reset : clock, synchronous active-high reset
//   load_i       : capture data_i (honoured only when empty)
//   unload_i     : release the entry (honoured only when full)
//   data_i       : incoming word
//   data_o       : buffered word (stale contents remain visible when empty)
//   full_o       : buffer holds a valid entry
module nic_channel_buf
  import cardinal_nic_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [0:WIDTH-1] data_i,
  output logic [0:WIDTH-1] data_o,
  output logic             full_o
);

  buf_state_e       state_q;
  logic [0:WIDTH-1] data_q;

  // Load is only seen in EMPTY and unload only in FULL, so a same-edge
  // load+unload can never both take effect.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= BUF_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (load_i) begin
            data_q  <= data_i;
            state_q <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (unload_i) state_q <= BUF_EMPTY;
        end
        default: state_q <= BUF_EMPTY;
      endcase
    end
  end

  assign data_o = data_q;
  assign full_o = (state_q == BUF_FULL);

endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: maps processor loads/stores on a 4-word register window onto
// packet traffic at the ring router's local port.
//   Clock, Reset : clock, synchronous active-high reset
//   bus (slave)  : addr/d_in/d_out/nicEn/nicWrEn processor side,
//                  net_si/net_ri/net_di ingress, net_so/net_ro/net_do egress,
//                  net_polarity current ring polarity
// Registers: 00 input buffer (read clears full), 01 input status,
//            10 output buffer (write), 11 output status.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  cardinal_nic_if.slave  bus
);

  logic [0:ADDR_WIDTH-1] addr;
  logic [0:DATA_WIDTH-1] in_data, out_data;
  logic [0:DATA_WIDTH-1] in_stat, out_stat;
  logic [0:DATA_WIDTH-1] d_out_d, d_out_q;
  logic                  in_full, out_full;
  logic                  rd_en, wr_out;
  logic                  in_load, in_unload;
  logic                  out_load, net_so;

  assign addr   = bus.addr;
  assign rd_en  = bus.nicEn & ~bus.nicWrEn;
  assign wr_out = bus.nicEn & bus.nicWrEn & (addr == NIC_OUT_BUF);

  assign in_load   = bus.net_si & ~in_full;
  assign in_unload = rd_en & (addr == NIC_IN_BUF);

  // Write accepted only if the buffer was empty before this edge; a write
  // racing a drain is dropped.
  assign out_load = wr_out & ~out_full;

  // Egress only on cycles whose polarity matches the packet's VC.
  assign net_so = out_full & bus.net_ro & (out_data[VC_BIT] == bus.net_polarity);

  nic_channel_buf #(.WIDTH(DATA_WIDTH)) u_in_buf (
    .Clock    (Clock),
    .Reset    (Reset),
    .load_i   (in_load),
    .unload_i (in_unload),
    .data_i   (bus.net_di),
    .data_o   (in_data),
    .full_o   (in_full)
  );

  nic_channel_buf #(.WIDTH(DATA_WIDTH)) u_out_buf (
    .Clock    (Clock),
    .Reset    (Reset),
    .load_i   (out_load),
    .unload_i (net_so),
    .data_i   (bus.d_in),
    .data_o   (out_data),
    .full_o   (out_full)
  );

  always_comb begin
    in_stat                 = '0;
    in_stat[DATA_WIDTH-1]   = in_full;
    out_stat                = '0;
    out_stat[DATA_WIDTH-1]  = out_full;
  end

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        NIC_IN_BUF:   d_out_d = in_data;
        NIC_IN_STAT:  d_out_d = in_stat;
        NIC_OUT_STAT: d_out_d = out_stat;
        default:      d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) d_out_q <= '0;
    else       d_out_q <= d_out_d;
  end

  assign bus.d_out  = d_out_q;
  assign bus.net_ri = ~in_full;
  assign bus.net_so = net_so;
  assign bus.net_do = out_data;

endmodule
